// File: rtl/spi_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// spi_reg_write_arbiter: round-robin sharing of the spi_slave write port
// among telemetry sources, publishing only changed or refreshed values.
// Revision: 1.0
// ============================================================================
module spi_reg_write_arbiter #(
   parameter int N_SRC  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_SRC*DATA_W-1:0]  src_data,
   input  logic [N_SRC*ADDR_W-1:0]  src_addr,
   input  logic [N_SRC-1:0]         src_en,
   input  logic                     refresh,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   output logic [$clog2(N_SRC)-1:0] grant_id,
   output logic                     busy
);
   localparam int GID_W = $clog2(N_SRC);
   localparam logic [GID_W-1:0] LAST_SRC = GID_W'(N_SRC - 1);

   logic [DATA_W-1:0] data_a [N_SRC];
   logic [ADDR_W-1:0] addr_a [N_SRC];
   logic [DATA_W-1:0] shadow [N_SRC];
   logic [N_SRC-1:0]  rfr;
   logic [N_SRC-1:0]  rfr_nxt;
   logic [N_SRC-1:0]  pending;
   logic [GID_W-1:0]  ptr;
   logic [GID_W-1:0]  gnt;
   logic              found;

   generate
      for (genvar i = 0; i < N_SRC; i++) begin : g_src
         assign data_a[i]  = src_data[i*DATA_W +: DATA_W];
         assign addr_a[i]  = src_addr[i*ADDR_W +: ADDR_W];
         assign pending[i] = src_en[i] & (rfr[i] | (data_a[i] != shadow[i]));
      end
   endgenerate

   assign busy = |pending;

   // Scan starts just after the last granted source, wrapping at N_SRC.
   always_comb begin
      logic [GID_W-1:0] idx;
      idx   = '0;
      gnt   = ptr;
      found = 1'b0;
      for (int k = 1; k <= N_SRC; k++) begin
         idx = GID_W'((int'(ptr) + k) % N_SRC);
         if (!found && pending[idx]) begin
            found = 1'b1;
            gnt   = idx;
         end
      end
   end

   // A refresh landing on the grant cycle re-arms the granted source.
   always_comb begin
      rfr_nxt = '0;
      for (int i = 0; i < N_SRC; i++) begin
         rfr_nxt[i] = (rfr[i] & ~(found && (gnt == GID_W'(i)))) | (refresh & src_en[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         grant_id <= '0;
         ptr      <= LAST_SRC;
         rfr      <= '1;
         for (int i = 0; i < N_SRC; i++) begin
            shadow[i] <= '0;
         end
      end else begin
         rfr <= rfr_nxt;
         if (found) begin
            wr_en       <= 1'b1;
            wr_addr     <= addr_a[gnt];
            wr_data     <= data_a[gnt];
            grant_id    <= gnt;
            shadow[gnt] <= data_a[gnt];
            ptr         <= gnt;
         end else begin
            wr_en <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_spi_reg_write_arbiter: directed stimulus with a scoreboard of expected
// register writes. Revision: 1.0
// ============================================================================
module tb_spi_reg_write_arbiter;
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         refresh = 1'b0;
   logic [3:0]   src_en = 4'b1111;
   logic [31:0]  d [4];
   logic [127:0] src_data;
   logic [127:0] src_addr;
   logic         wr_en;
   logic [31:0]  wr_addr;
   logic [31:0]  wr_data;
   logic [1:0]   grant_id;
   logic         busy;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  gid;
   } exp_t;

   exp_t q[$];
   int   passed = 0;
   int   total = 0;

   assign src_data = {d[3], d[2], d[1], d[0]};
   assign src_addr = {32'd3, 32'd2, 32'd1, 32'd0};

   spi_reg_write_arbiter #(.N_SRC(4), .DATA_W(32), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset), .src_data(src_data), .src_addr(src_addr),
      .src_en(src_en), .refresh(refresh), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int g, input logic [31:0] v);
      exp_t e;
      e.addr = 32'(g);
      e.data = v;
      e.gid  = 2'(g);
      q.push_back(e);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40; i++) begin
         if (q.size() == 0 && !busy) break;
         step();
      end
      chk({name, "_queue_empty"}, 128'(q.size()), 128'd0);
      chk({name, "_idle"}, 128'(busy), 128'd0);
      step(2);
   endtask

   // Monitor: every write the DUT presents must match the head of the queue.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (wr_en) begin
            if (q.size() == 0) begin
               total++;
               $display("FAIL unexpected_write: got gid=%0d addr=%0d data=%h, expected no write",
                        grant_id, wr_addr, wr_data);
            end else begin
               e = q.pop_front();
               chk("write", {wr_addr, wr_data, 30'd0, grant_id}, {e.addr, e.data, 30'd0, e.gid});
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      d[0] = 32'h1111_0000;
      d[1] = 32'h2222_0000;
      d[2] = 32'h3333_0000;
      d[3] = 32'h4444_0000;

      // Reset release: every enabled source published once in order 0..3
      step(3);
      chk("rst_wr_en", 128'(wr_en), 128'd0);
      chk("rst_wr_addr", 128'(wr_addr), 128'd0);
      chk("rst_wr_data", 128'(wr_data), 128'd0);
      chk("rst_grant_id", 128'(grant_id), 128'd0);
      for (int i = 0; i < 4; i++) push(i, d[i]);
      reset = 1'b0;
      drain("t1");

      // All sources change every cycle: strict rotation, value at grant edge
      for (int k = 1; k <= 12; k++) begin
         for (int i = 0; i < 4; i++) d[i] = d[i] + 32'd1;
         push((k - 1) % 4, d[(k - 1) % 4]);
         step();
      end
      push(0, d[0]);
      push(1, d[1]);
      push(2, d[2]);
      drain("t3");

      // Reset in the middle of a burst, then restart from source 0
      for (int i = 0; i < 4; i++) d[i] = 32'hE000_0000 + 32'(i);
      push(3, d[3]);
      push(0, d[0]);
      step(2);
      reset = 1'b1;
      step();
      chk("midrst_wr_en", 128'(wr_en), 128'd0);
      chk("midrst_wr_data", 128'(wr_data), 128'd0);
      for (int i = 0; i < 4; i++) push(i, d[i]);
      reset = 1'b0;
      drain("t6");

      // Single change: one write, one cycle later
      d[2] = 32'h0000_1234;
      push(2, d[2]);
      step();
      chk("t2_latency_wr_en", 128'(wr_en), 128'd1);
      chk("t2_latency_gid", 128'(grant_id), 128'd2);
      drain("t2");

      // Disabled source ignored until re-enabled
      src_en[1] = 1'b0;
      d[1] = 32'd5;
      step(3);
      chk("t4_disabled_idle", 128'(busy), 128'd0);
      src_en[1] = 1'b1;
      push(1, 32'd5);
      step();
      chk("t4_reenable_wr_en", 128'(wr_en), 128'd1);
      chk("t4_reenable_gid", 128'(grant_id), 128'd1);
      drain("t4");

      // Refresh while idle, source 2 disabled; pointer sits at 1
      src_en  = 4'b1011;
      refresh = 1'b1;
      step();
      refresh = 1'b0;
      chk("t5_refresh_busy", 128'(busy), 128'd1);
      push(3, d[3]);
      push(0, d[0]);
      push(1, d[1]);
      drain("t5a");

      // Refresh on the grant cycle of source 0: source 0 written twice
      d[0]    = 32'hF0F0_F0F0;
      refresh = 1'b1;
      push(0, d[0]);
      push(1, d[1]);
      push(3, d[3]);
      push(0, d[0]);
      step();
      refresh = 1'b0;
      drain("t5b");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
